// File: rtl/gen_write_sequencer.sv
// Register-write port owner for the signal generator: host writes and a
// tick-paced step sequencer share one registered strobe/address/data output.
module gen_write_sequencer #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 3,
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               host_strobe_i,
  input  logic [2:0]         host_addr_i,
  input  logic [4:0]         host_data_i,
  input  logic               prog_we_i,
  input  logic [IDX_W-1:0]   prog_idx_i,
  input  logic [2:0]         prog_addr_i,
  input  logic [4:0]         prog_data_i,
  input  logic [DELAY_W-1:0] prog_delay_i,
  input  logic [IDX_W:0]     seq_len_i,
  input  logic               run_i,
  input  logic               loop_i,
  output logic               gen_strobe_o,
  output logic [2:0]         gen_addr_o,
  output logic [4:0]         gen_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   step_idx_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     step_q, step_d;
  logic [DELAY_W-1:0]   cnt_q, cnt_d;

  logic [2:0]           addr_mem_q  [DEPTH];
  logic [4:0]           data_mem_q  [DEPTH];
  logic [DELAY_W-1:0]   delay_mem_q [DEPTH];

  logic                 hs_meta_q, hs_sync_q, hs_prev_q;
  logic                 host_rise;
  logic                 pend_q, pend_d;
  logic [2:0]           pend_addr_q, pend_addr_d;
  logic [4:0]           pend_data_q, pend_data_d;

  logic                 gen_strobe_q, gen_strobe_d;
  logic [2:0]           gen_addr_q, gen_addr_d;
  logic [4:0]           gen_data_q, gen_data_d;

  logic                 seq_go;
  logic                 advance;
  logic                 last_step;
  logic [IDX_W:0]       eff_len;

  // Lengths beyond the table size simply run the whole table.
  assign eff_len   = (seq_len_i > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : seq_len_i;
  assign last_step = (eff_len == '0) || ({1'b0, step_q} >= (eff_len - 1'b1));
  assign host_rise = hs_sync_q & ~hs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i]  <= '0;
        data_mem_q[i]  <= '0;
        delay_mem_q[i] <= '0;
      end
    end else if (prog_we_i) begin
      addr_mem_q[prog_idx_i]  <= prog_addr_i;
      data_mem_q[prog_idx_i]  <= prog_data_i;
      delay_mem_q[prog_idx_i] <= prog_delay_i;
    end
  end

  // The pending slot holds a host write for exactly one cycle since the host always wins.
  always_comb begin
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (host_rise) begin
      pend_d      = 1'b1;
      pend_addr_d = host_addr_i;
      pend_data_d = host_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    seq_go  = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_i && eff_len != '0) begin
          state_d = S_ISSUE;
          step_d  = '0;
        end
      end
      S_ISSUE: begin
        if (!run_i) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else if (!pend_q) begin
          seq_go = 1'b1;
          cnt_d  = delay_mem_q[step_q];
          if (delay_mem_q[step_q] == '0) advance = 1'b1;
          else                           state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!run_i) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else if (tick_i) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DELAY_W'(1)) advance = 1'b1;
        end
      end
      S_DONE: begin
        if (!run_i) begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
    if (advance) begin
      if (last_step) begin
        if (loop_i && eff_len != '0) begin
          step_d  = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        step_d  = step_q + 1'b1;
        state_d = S_ISSUE;
      end
    end
  end

  always_comb begin
    gen_strobe_d = pend_q | seq_go;
    gen_addr_d   = gen_addr_q;
    gen_data_d   = gen_data_q;
    if (pend_q) begin
      gen_addr_d = pend_addr_q;
      gen_data_d = pend_data_q;
    end else if (seq_go) begin
      gen_addr_d = addr_mem_q[step_q];
      gen_data_d = data_mem_q[step_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      cnt_q        <= '0;
      hs_meta_q    <= 1'b0;
      hs_sync_q    <= 1'b0;
      hs_prev_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      gen_strobe_q <= 1'b0;
      gen_addr_q   <= '0;
      gen_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      hs_meta_q    <= host_strobe_i;
      hs_sync_q    <= hs_meta_q;
      hs_prev_q    <= hs_sync_q;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      gen_strobe_q <= gen_strobe_d;
      gen_addr_q   <= gen_addr_d;
      gen_data_q   <= gen_data_d;
    end
  end

  assign gen_strobe_o = gen_strobe_q;
  assign gen_addr_o   = gen_addr_q;
  assign gen_data_o   = gen_data_q;
  assign busy_o       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done_o       = (state_q == S_DONE);
  assign step_idx_o   = step_q;

endmodule

// File: tb/tb_gen_write_sequencer.sv
// Scoreboard bench for gen_write_sequencer: expected writes are queued as stimulus
// is driven and matched against each gen_strobe by the monitor.
module tb_gen_write_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       host_strobe = 1'b0;
  logic [2:0] host_addr = '0;
  logic [4:0] host_data = '0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_idx = '0;
  logic [2:0] prog_addr = '0;
  logic [4:0] prog_data = '0;
  logic [7:0] prog_delay = '0;
  logic [3:0] seq_len = '0;
  logic       run = 1'b0;
  logic       loop_en = 1'b0;
  logic       gen_strobe;
  logic [2:0] gen_addr;
  logic [4:0] gen_data;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;

  typedef struct {int addr; int data; int cyc;} exp_t;
  exp_t exp_q[$];
  int   stb_cyc[$];
  bit   tick_at[int];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   stb_cnt = 0;
  bit   tick_en = 1'b0;

  gen_write_sequencer #(.DEPTH(8), .IDX_W(3), .DELAY_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick),
    .host_strobe_i(host_strobe), .host_addr_i(host_addr), .host_data_i(host_data),
    .prog_we_i(prog_we), .prog_idx_i(prog_idx), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .prog_delay_i(prog_delay),
    .seq_len_i(seq_len), .run_i(run), .loop_i(loop_en),
    .gen_strobe_o(gen_strobe), .gen_addr_o(gen_addr), .gen_data_o(gen_data),
    .busy_o(busy), .done_o(done), .step_idx_o(step_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per transaction; pops the scoreboard on every strobe.
  always @(posedge clk) begin
    exp_t e;
    #1;
    tick_at[cyc] = tick;
    if (gen_strobe === 1'b1) begin
      stb_cnt++;
      stb_cyc.push_back(cyc);
      $display("cyc %0d: write addr=%0d data=0x%02h step_idx=%0d", cyc, gen_addr, gen_data, step_idx);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe cyc=%0d got addr=%0d data=0x%02h, required no strobe", cyc, gen_addr, gen_data);
      end else begin
        e = exp_q.pop_front();
        if (gen_addr !== 3'(e.addr) || gen_data !== 5'(e.data))
          $display("FAIL wr_payload cyc=%0d got addr=%0d data=0x%02h, required addr=%0d data=0x%02h",
                   cyc, gen_addr, gen_data, e.addr, e.data);
        else if (e.cyc >= 0 && cyc != e.cyc)
          $display("FAIL wr_cycle got cyc=%0d, required cyc=%0d", cyc, e.cyc);
        else
          pass_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = tick_en && ((cyc % 4) == 0);
    end
  endtask

  task automatic push_exp(input int a, input int d, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic prog(input int idx, input int a, input int d, input int dl);
    prog_we = 1'b1;
    prog_idx = idx[2:0]; prog_addr = a[2:0]; prog_data = d[4:0]; prog_delay = dl[7:0];
    step(1);
    prog_we = 1'b0;
  endtask

  task automatic wait_stb(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (stb_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  function automatic int count_ticks(input int a, input int b);
    int n = 0;
    for (int k = a + 1; k <= b; k++)
      if (tick_at.exists(k) && tick_at[k]) n++;
    return n;
  endfunction

  task automatic test_reset();
    step(2);
    total_cnt++;
    if ({gen_strobe, gen_addr, gen_data, busy, done, step_idx} !== 14'd0)
      $display("FAIL reset_outputs got=%b, required all zero", {gen_strobe, gen_addr, gen_data, busy, done, step_idx});
    else pass_cnt++;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_host();
    int c;
    int start;
    bit seen_busy = 1'b0;
    start = stb_cnt;
    c = cyc;
    host_addr = 3'd3; host_data = 5'h15; host_strobe = 1'b1;
    push_exp(3, 'h15, c + 4);
    step(3);
    host_strobe = 1'b0; host_addr = '0; host_data = '0;
    repeat (8) begin
      step(1);
      if (busy !== 1'b0 || done !== 1'b0) seen_busy = 1'b1;
    end
    total_cnt++;
    if (stb_cnt - start != 1) $display("FAIL host_strobe_count got=%0d, required 1", stb_cnt - start);
    else pass_cnt++;
    total_cnt++;
    if (seen_busy) $display("FAIL host_busy_done got busy/done high, required both 0");
    else pass_cnt++;
    total_cnt++;
    if (gen_addr !== 3'd3 || gen_data !== 5'h15)
      $display("FAIL host_hold got addr=%0d data=0x%02h, required addr=3 data=0x15", gen_addr, gen_data);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    int start;
    bit ok;
    int e0, e1, e2;
    prog(0, 1, 'h01, 2);
    prog(1, 2, 'h02, 0);
    prog(2, 4, 'h04, 1);
    seq_len = 4'd3; loop_en = 1'b0; tick_en = 1'b1;
    start = stb_cnt;
    push_exp(1, 'h01, -1); push_exp(2, 'h02, -1); push_exp(4, 'h04, -1);
    run = 1'b1;
    wait_done(200, ok);
    total_cnt++;
    if (!ok || stb_cnt - start != 3) $display("FAIL seq_done got done=%0b strobes=%0d, required done=1 strobes=3", ok, stb_cnt - start);
    else pass_cnt++;
    if (ok && stb_cnt - start == 3) begin
      e0 = stb_cyc[start]; e1 = stb_cyc[start + 1]; e2 = stb_cyc[start + 2];
      total_cnt++;
      if (count_ticks(e0, e1 - 1) != 2 || !tick_at[e1 - 1])
        $display("FAIL seq_delay0 got ticks=%0d, required 2 ticks ending the wait", count_ticks(e0, e1 - 1));
      else pass_cnt++;
      total_cnt++;
      if (e2 - e1 != 1) $display("FAIL seq_back_to_back got gap=%0d, required 1", e2 - e1);
      else pass_cnt++;
    end
    total_cnt++;
    if (step_idx !== 3'd2) $display("FAIL seq_last_idx got=%0d, required 2", step_idx);
    else pass_cnt++;
    run = 1'b0;
    step(2);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL seq_to_idle got done=%0b busy=%0b, required 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c;
    int start;
    bit ok;
    int e0, e1, e2;
    prog(0, 6, 'h11, 1);
    prog(1, 7, 'h12, 0);
    seq_len = 4'd2;
    start = stb_cnt;
    c = cyc;
    host_addr = 3'd5; host_data = 5'h0A; host_strobe = 1'b1;
    push_exp(5, 'h0A, c + 4);
    push_exp(6, 'h11, c + 5);
    push_exp(7, 'h12, -1);
    step(2);
    run = 1'b1;
    step(2);
    host_strobe = 1'b0;
    wait_done(200, ok);
    total_cnt++;
    if (!ok || stb_cnt - start != 3) $display("FAIL coll_done got done=%0b strobes=%0d, required done=1 strobes=3", ok, stb_cnt - start);
    else pass_cnt++;
    if (ok && stb_cnt - start == 3) begin
      e0 = stb_cyc[start]; e1 = stb_cyc[start + 1]; e2 = stb_cyc[start + 2];
      total_cnt++;
      if (e1 - e0 != 1) $display("FAIL coll_consecutive got gap=%0d, required 1", e1 - e0);
      else pass_cnt++;
      total_cnt++;
      if (count_ticks(e1, e2 - 1) != 1 || !tick_at[e2 - 1])
        $display("FAIL coll_delay got ticks=%0d, required 1 tick counted from the later strobe", count_ticks(e1, e2 - 1));
      else pass_cnt++;
    end
    run = 1'b0;
    step(2);
  endtask

  task automatic test_loop();
    int start;
    int wraps = 0;
    bit seen1 = 1'b0;
    bit reached = 1'b0;
    prog(0, 1, 'h03, 1);
    prog(1, 2, 'h1C, 1);
    seq_len = 4'd2; loop_en = 1'b1;
    start = stb_cnt;
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 'h03, -1);
      push_exp(2, 'h1C, -1);
    end
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (step_idx === 3'd1) seen1 = 1'b1;
      if (seen1 && step_idx === 3'd0) begin wraps++; seen1 = 1'b0; end
      if (stb_cnt >= start + 6) begin reached = 1'b1; break; end
    end
    run = 1'b0;
    step(3);
    total_cnt++;
    if (!reached) $display("FAIL loop_passes got strobes=%0d, required 6", stb_cnt - start);
    else pass_cnt++;
    total_cnt++;
    if (wraps < 2) $display("FAIL loop_wrap got wraps=%0d, required >=2", wraps);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || step_idx !== 3'd0)
      $display("FAIL loop_abort got busy=%0b done=%0b idx=%0d, required 0 0 0", busy, done, step_idx);
    else pass_cnt++;
    loop_en = 1'b0;
  endtask

  task automatic test_abort();
    int start;
    bit ok;
    prog(0, 1, 'h09, 1);
    prog(1, 4, 'h0E, 9);
    prog(2, 2, 'h07, 0);
    seq_len = 4'd3;
    start = stb_cnt;
    push_exp(1, 'h09, -1); push_exp(4, 'h0E, -1);
    run = 1'b1;
    wait_stb(start + 2, 200, ok);
    step(2);
    total_cnt++;
    if (!ok || busy !== 1'b1 || step_idx !== 3'd1)
      $display("FAIL abort_in_wait got ok=%0b busy=%0b idx=%0d, required 1 1 1", ok, busy, step_idx);
    else pass_cnt++;
    run = 1'b0;
    step(1);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || step_idx !== 3'd0)
      $display("FAIL abort_idle got busy=%0b done=%0b idx=%0d, required 0 0 0", busy, done, step_idx);
    else pass_cnt++;
    step(40);
    total_cnt++;
    if (stb_cnt - start != 2) $display("FAIL abort_quiet got strobes=%0d, required 2", stb_cnt - start);
    else pass_cnt++;

    start = stb_cnt;
    push_exp(1, 'h09, -1); push_exp(4, 'h0E, -1);
    run = 1'b1;
    wait_stb(start + 2, 200, ok);
    step(2);
    total_cnt++;
    if (!ok || gen_addr !== 3'd4 || busy !== 1'b1)
      $display("FAIL rst_pre got ok=%0b addr=%0d busy=%0b, required 1 4 1", ok, gen_addr, busy);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({gen_strobe, gen_addr, gen_data, busy, done, step_idx} !== 14'd0)
      $display("FAIL rst_async got=%b, required all zero", {gen_strobe, gen_addr, gen_data, busy, done, step_idx});
    else pass_cnt++;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(40);
    total_cnt++;
    if (stb_cnt - start != 2) $display("FAIL rst_quiet got strobes=%0d, required 2", stb_cnt - start);
    else pass_cnt++;
  endtask

  task automatic test_seq_len();
    int start;
    bit ok;
    bit seen_busy = 1'b0;
    seq_len = 4'd0;
    start = stb_cnt;
    run = 1'b1;
    repeat (20) begin
      step(1);
      if (busy !== 1'b0) seen_busy = 1'b1;
    end
    run = 1'b0;
    total_cnt++;
    if (seen_busy || stb_cnt != start) $display("FAIL len0 got busy=%0b strobes=%0d, required 0 0", seen_busy, stb_cnt - start);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) prog(i, i, (i * 3 + 1) % 32, 0);
    seq_len = 4'd9;
    start = stb_cnt;
    for (int i = 0; i < 8; i++) push_exp(i, (i * 3 + 1) % 32, -1);
    run = 1'b1;
    wait_done(100, ok);
    total_cnt++;
    if (!ok || stb_cnt - start != 8) $display("FAIL len9 got done=%0b strobes=%0d, required 1 8", ok, stb_cnt - start);
    else pass_cnt++;
    total_cnt++;
    if (step_idx !== 3'd7) $display("FAIL len9_idx got=%0d, required 7", step_idx);
    else pass_cnt++;
    run = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_host();
    test_sequence();
    test_back_to_back();
    test_loop();
    test_abort();
    test_seq_len();
    step(4);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d pending, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
